dot_product_accumulator: RTL

//  Downstream stage of the vector multiplier. Consumes a stream of unsigned element products,
//  one per clock. Sums each group of N consecutive products into one dot-product result.

---
 rtl/dot_product_accumulator_pkg.sv | 19 +
 rtl/dot_product_accumulator_if.sv | 31 +++
 rtl/dot_product_accumulator_elem_counter.sv | 48 ++++
 rtl/dot_product_accumulator.sv | 83 ++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator: width helpers and the
// ACCUM/LAST vector-position encoding also used by the multiplier control.
package dot_product_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } vec_state_e;

  // Result width: an unsigned sum of n products of 2*w bits cannot overflow.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned w);
    return 2 * w + int'($clog2(n));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product-in / sum-out stream bundle between the multiplier, the accumulator
// and the result consumer.
interface dot_product_accumulator_if
  import dot_product_accumulator_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 3
);
  localparam int unsigned ACC_W = acc_width(N, W);
  localparam int unsigned IDX_W = idx_width(N);

  logic               prod_valid;
  logic [2*W-1:0]     prod_in;
  logic               prod_ready;
  logic               clear;
  logic               sum_valid;
  logic [ACC_W-1:0]   sum_out;
  logic               sum_ready;
  logic [IDX_W-1:0]   elem_idx;

  modport master (
    output prod_valid, prod_in, clear, sum_ready,
    input  prod_ready, sum_valid, sum_out, elem_idx
  );

  modport slave (
    input  prod_valid, prod_in, clear, sum_ready,
    output prod_ready, sum_valid, sum_out, elem_idx
  );

endinterface

// File: rtl/dot_product_accumulator_elem_counter.sv
// Modulo-N element counter tracking the position inside the current vector,
// with the ACCUM/LAST position state kept alongside the index.
module dot_product_accumulator_elem_counter
  import dot_product_accumulator_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             is_last_c
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam vec_state_e       RST_STATE = (N == 1) ? ST_LAST : ST_ACCUM;

  vec_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Wrap to zero after the last element; state follows the next index.
  always_comb begin
    idx_d   = idx_q;
    state_d = state_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = (state_q == ST_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    state_d = (idx_d == LAST_IDX) ? ST_LAST : ST_ACCUM;
  end

  assign idx       = idx_q;
  assign is_last_c = (state_q == ST_LAST);

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums each group of N unsigned products into a dot product and holds it in a
// one-entry result buffer so the next vector can accumulate meanwhile.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  dot_product_accumulator_if.slave bus
);

  localparam int unsigned ACC_W = acc_width(N, W);
  localparam int unsigned IDX_W = idx_width(N);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0] prod_ext_c;
  logic [IDX_W-1:0] elem_idx;
  logic             is_last_c;
  logic             prod_ready_c;
  logic             accept_c;
  logic             take_c;

  // Only the last element stalls, and only behind an untaken result.
  assign prod_ready_c = !(is_last_c && sum_valid_q && !bus.sum_ready);
  assign accept_c     = bus.prod_valid && prod_ready_c;
  assign take_c       = sum_valid_q && bus.sum_ready;
  assign prod_ext_c   = ACC_W'(bus.prod_in);

  dot_product_accumulator_elem_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_elem_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (accept_c && !bus.clear),
    .clr       (bus.clear),
    .idx       (elem_idx),
    .is_last_c (is_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  // A last-element accept in the same cycle as a take refills the buffer with no bubble.
  always_comb begin
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    if (take_c) begin
      sum_valid_d = 1'b0;
    end
    if (bus.clear) begin
      acc_d = '0;
    end else if (accept_c) begin
      if (is_last_c) begin
        sum_d       = acc_q + prod_ext_c;
        sum_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_q + prod_ext_c;
      end
    end
  end

  assign bus.prod_ready = prod_ready_c;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.sum_out    = sum_q;
  assign bus.elem_idx   = elem_idx;

endmodule
